pkt_gen_tx: RTL and testbench

PKT_GEN_TX -- requirements
Module: pkt_gen_tx

---
 rtl/pkt_gen_tx.sv | 214 +++++++++++++++++++++
 tb/tb_pkt_gen_tx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_gen_tx.sv
// Test-traffic packet generator: emits a header word followed by ceil(len/8) payload
// words per packet, with optional inter-packet gap, and keeps run statistics.
module pkt_gen_tx #(
  parameter int          DATA_WIDTH     = 64,
  parameter int          CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int          TIME_WIDTH     = 64,
  parameter int          BYTE_CNT_WIDTH = 40,
  parameter logic [15:0] SRC_PORT       = 16'h0000
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [CTRL_WIDTH-1:0]     out_ctrl,
  output logic                      out_wr,
  input  logic                      out_rdy,
  input  logic                      enable,
  input  logic [31:0]               num_pkts,
  input  logic [15:0]               pkt_len,
  input  logic [31:0]               ipg_cycles,
  input  logic [15:0]               dst_port,
  input  logic [TIME_WIDTH-1:0]     time_now,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               pkt_cnt,
  output logic [BYTE_CNT_WIDTH-1:0] byte_cnt,
  output logic [TIME_WIDTH-1:0]     time_first,
  output logic [TIME_WIDTH-1:0]     time_last
);

  localparam int DW64 = (DATA_WIDTH > 64) ? DATA_WIDTH : 64;
  localparam int WW   = (TIME_WIDTH > DW64) ? TIME_WIDTH : DW64;
  localparam int CW   = (CTRL_WIDTH > 8) ? CTRL_WIDTH : 8;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_GAP, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic                      en_prev_q, en_prev_d;
  logic [31:0]               num_pkts_q, num_pkts_d;
  logic [15:0]               len_q, len_d;
  logic [15:0]               word_len_q, word_len_d;
  logic [31:0]               ipg_q, ipg_d;
  logic [15:0]               dst_q, dst_d;
  logic [15:0]               word_idx_q, word_idx_d;
  logic [31:0]               gap_cnt_q, gap_cnt_d;
  logic [31:0]               seq_q, seq_d;
  logic                      first_q, first_d;
  logic [TIME_WIDTH-1:0]     hdr_ts_q, hdr_ts_d;
  logic [31:0]               pkt_cnt_q, pkt_cnt_d;
  logic [BYTE_CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [TIME_WIDTH-1:0]     time_first_q, time_first_d;
  logic [TIME_WIDTH-1:0]     time_last_q, time_last_d;

  logic [15:0] clamped_len;
  logic [31:0] pkt_cnt_inc;
  logic        last_word;
  logic [2:0]  last_shift;
  logic [WW-1:0] word_w;
  logic [CW-1:0] ctrl_w;

  assign clamped_len = (pkt_len < 16'd60)   ? 16'd60 :
                       (pkt_len > 16'd1514) ? 16'd1514 : pkt_len;
  assign pkt_cnt_inc = pkt_cnt_q + 32'd1;
  assign last_word   = (word_idx_q == word_len_q - 16'd1);
  assign last_shift  = 3'(len_q - 16'd1);

  // Next-state and datapath updates; nothing advances in HDR/PAYLOAD without out_rdy
  always_comb begin
    state_d      = state_q;
    en_prev_d    = enable;
    num_pkts_d   = num_pkts_q;
    len_d        = len_q;
    word_len_d   = word_len_q;
    ipg_d        = ipg_q;
    dst_d        = dst_q;
    word_idx_d   = word_idx_q;
    gap_cnt_d    = gap_cnt_q;
    seq_d        = seq_q;
    first_d      = first_q;
    hdr_ts_d     = hdr_ts_q;
    pkt_cnt_d    = pkt_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    time_first_d = time_first_q;
    time_last_d  = time_last_q;
    case (state_q)
      S_IDLE: begin
        if (enable && !en_prev_q) begin
          num_pkts_d   = num_pkts;
          len_d        = clamped_len;
          word_len_d   = (clamped_len + 16'd7) >> 3;
          ipg_d        = ipg_cycles;
          dst_d        = dst_port;
          pkt_cnt_d    = '0;
          byte_cnt_d   = '0;
          time_first_d = '0;
          time_last_d  = '0;
          seq_d        = '0;
          first_d      = 1'b1;
          state_d      = S_HDR;
        end
      end
      S_HDR: begin
        if (out_rdy) begin
          time_last_d = time_now;
          hdr_ts_d    = time_now;
          if (first_q) time_first_d = time_now;
          first_d     = 1'b0;
          word_idx_d  = '0;
          state_d     = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (out_rdy) begin
          if (last_word) begin
            pkt_cnt_d  = pkt_cnt_inc;
            byte_cnt_d = byte_cnt_q + BYTE_CNT_WIDTH'(len_q);
            seq_d      = seq_q + 32'd1;
            if ((num_pkts_q != 32'd0) && (pkt_cnt_inc == num_pkts_q)) state_d = S_DONE;
            else if (!enable)                                        state_d = S_IDLE;
            else if (ipg_q == 32'd0)                                 state_d = S_HDR;
            else begin
              gap_cnt_d = ipg_q;
              state_d   = S_GAP;
            end
          end else begin
            word_idx_d = word_idx_q + 16'd1;
          end
        end
      end
      S_GAP: begin
        if (!enable)                   state_d = S_IDLE;
        else if (gap_cnt_q <= 32'd1)   state_d = S_HDR;
        else                           gap_cnt_d = gap_cnt_q - 32'd1;
      end
      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output word is a pure function of registered state, so it holds while stalled
  always_comb begin
    word_w = '0;
    ctrl_w = '0;
    case (state_q)
      S_HDR: begin
        word_w = WW'({dst_q, word_len_q, SRC_PORT, len_q});
        ctrl_w = CW'(8'hFF);
      end
      S_PAYLOAD: begin
        case (word_idx_q)
          16'd0:   word_w = WW'(hdr_ts_q);
          16'd1:   word_w = WW'({seq_q, len_q, 16'h0000});
          default: word_w = WW'({32'hA5A5_A5A5, 16'h0000, word_idx_q});
        endcase
        ctrl_w = last_word ? CW'(8'h80 >> last_shift) : '0;
      end
      default: begin
        word_w = '0;
        ctrl_w = '0;
      end
    endcase
  end

  assign out_data   = word_w[DATA_WIDTH-1:0];
  assign out_ctrl   = ctrl_w[CTRL_WIDTH-1:0];
  assign out_wr     = ((state_q == S_HDR) || (state_q == S_PAYLOAD)) && out_rdy;
  assign busy       = (state_q == S_HDR) || (state_q == S_PAYLOAD) || (state_q == S_GAP);
  assign done       = (state_q == S_DONE);
  assign pkt_cnt    = pkt_cnt_q;
  assign byte_cnt   = byte_cnt_q;
  assign time_first = time_first_q;
  assign time_last  = time_last_q;

  // en_prev tracks enable during reset so a level held across reset is not an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      en_prev_q    <= enable;
      num_pkts_q   <= '0;
      len_q        <= '0;
      word_len_q   <= '0;
      ipg_q        <= '0;
      dst_q        <= '0;
      word_idx_q   <= '0;
      gap_cnt_q    <= '0;
      seq_q        <= '0;
      first_q      <= 1'b0;
      hdr_ts_q     <= '0;
      pkt_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      time_first_q <= '0;
      time_last_q  <= '0;
    end else begin
      state_q      <= state_d;
      en_prev_q    <= en_prev_d;
      num_pkts_q   <= num_pkts_d;
      len_q        <= len_d;
      word_len_q   <= word_len_d;
      ipg_q        <= ipg_d;
      dst_q        <= dst_d;
      word_idx_q   <= word_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      seq_q        <= seq_d;
      first_q      <= first_d;
      hdr_ts_q     <= hdr_ts_d;
      pkt_cnt_q    <= pkt_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      time_first_q <= time_first_d;
      time_last_q  <= time_last_d;
    end
  end

endmodule

// File: tb/tb_pkt_gen_tx.sv
// Bench for pkt_gen_tx: table-driven runs, randomized runs scored against a packet-layout
// model, and hand-written reset / enable corner sequences.
module tb_pkt_gen_tx;

  localparam logic [15:0] SRC = 16'h1234;

  logic        clk;
  logic        reset;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        enable;
  logic [31:0] num_pkts;
  logic [15:0] pkt_len;
  logic [31:0] ipg_cycles;
  logic [15:0] dst_port;
  logic [63:0] time_now;
  logic        busy;
  logic        done;
  logic [31:0] pkt_cnt;
  logic [39:0] byte_cnt;
  logic [63:0] time_first;
  logic [63:0] time_last;

  pkt_gen_tx #(
    .DATA_WIDTH(64), .CTRL_WIDTH(8), .TIME_WIDTH(64), .BYTE_CNT_WIDTH(40), .SRC_PORT(SRC)
  ) dut (
    .clk(clk), .reset(reset),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .enable(enable), .num_pkts(num_pkts), .pkt_len(pkt_len), .ipg_cycles(ipg_cycles),
    .dst_port(dst_port), .time_now(time_now),
    .busy(busy), .done(done), .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt),
    .time_first(time_first), .time_last(time_last)
  );

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  longint      cycle = 0;
  bit          rdy_rand = 1'b0;
  int          wr_no_rdy = 0;

  logic [63:0] cap_data[$];
  logic [7:0]  cap_ctrl[$];
  logic [63:0] cap_ts[$];
  longint      cap_cyc[$];

  typedef struct {
    int unsigned    num_pkts;
    int unsigned    pkt_len;
    int unsigned    ipg;
    logic [15:0]    dst;
    bit             rr;
    bit             check_gap;
    int unsigned    exp_words;
    int unsigned    exp_wl;
    logic [7:0]     exp_last_ctrl;
    longint unsigned exp_bytes;
  } vec_t;

  vec_t vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timestamp and ready are driven just after each rising edge
  initial begin
    time_now = 64'h0000_0100_0000_0000;
    out_rdy  = 1'b1;
    forever begin
      @(posedge clk);
      cycle++;
      #1;
      time_now = time_now + 64'd3;
      out_rdy  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Every word presented with out_wr is transferred on the following rising edge
  always @(negedge clk) begin
    if (out_wr && !out_rdy) wr_no_rdy++;
    if (out_wr) begin
      cap_data.push_back(out_data);
      cap_ctrl.push_back(out_ctrl);
      cap_ts.push_back(time_now);
      cap_cyc.push_back(cycle);
    end
  end

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int unsigned clampLen(input int unsigned l);
    if (l < 60) return 60;
    if (l > 1514) return 1514;
    return l;
  endfunction

  function automatic logic [63:0] expWord(input int unsigned p, input int unsigned i,
                                          input int unsigned len, input logic [15:0] dst,
                                          input logic [63:0] ts);
    int unsigned wl = (len + 7) / 8;
    if (i == 0) return {dst, 16'(wl), SRC, 16'(len)};
    if (i == 1) return ts;
    if (i == 2) return {32'(p), 16'(len), 16'h0000};
    return {32'hA5A5_A5A5, 32'(i - 1)};
  endfunction

  function automatic logic [7:0] expCtrl(input int unsigned i, input int unsigned len);
    int unsigned wl = (len + 7) / 8;
    if (i == 0) return 8'hFF;
    if (i == wl) return 8'h80 >> ((len - 1) % 8);
    return 8'h00;
  endfunction

  task automatic clearCapture();
    cap_data.delete();
    cap_ctrl.delete();
    cap_ts.delete();
    cap_cyc.delete();
    wr_no_rdy = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic startRun(input int unsigned n, input int unsigned len, input int unsigned ipg,
                          input logic [15:0] dst, input bit rr);
    enable     = 1'b0;
    num_pkts   = n;
    pkt_len    = 16'(len);
    ipg_cycles = ipg;
    dst_port   = dst;
    repeat (3) tick();
    rdy_rand = rr;
    clearCapture();
    enable = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, output bit finished);
    int budget = int'(v.exp_words) * 4 + int'(v.num_pkts * v.ipg) * 2 + 100;
    startRun(v.num_pkts, v.pkt_len, v.ipg, v.dst, v.rr);
    finished = 1'b0;
    for (int c = 0; c < budget && !finished; c++) begin
      tick();
      if (done === 1'b1) finished = 1'b1;
    end
    rdy_rand = 1'b0;
  endtask

  // Whole-run scoreboard: packet p, word i derived from the packet layout rules
  task automatic verifyStream(input string tag, input int unsigned n, input int unsigned len,
                              input logic [15:0] dst);
    int unsigned wl = (len + 7) / 8;
    int unsigned total = n * (wl + 1);
    checkOutput($sformatf("%s word_count", tag), 64'(cap_data.size()), 64'(total));
    for (int idx = 0; idx < cap_data.size() && idx < int'(total); idx++) begin
      int unsigned p = idx / (wl + 1);
      int unsigned i = idx % (wl + 1);
      logic [63:0] ts = cap_ts[p * (wl + 1)];
      checkOutput($sformatf("%s data p%0d w%0d", tag, p, i), cap_data[idx], expWord(p, i, len, dst, ts));
      checkOutput($sformatf("%s ctrl p%0d w%0d", tag, p, i), 64'(cap_ctrl[idx]), 64'(expCtrl(i, len)));
    end
    if (total > 0 && cap_ts.size() >= int'(total)) begin
      checkOutput($sformatf("%s time_first", tag), time_first, cap_ts[0]);
      checkOutput($sformatf("%s time_last", tag), time_last, cap_ts[(n - 1) * (wl + 1)]);
    end
    checkOutput($sformatf("%s wr_without_rdy", tag), 64'(wr_no_rdy), 64'd0);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    bit finished;
    int unsigned L = clampLen(v.pkt_len);
    applyStimulus(v, finished);
    checkOutput($sformatf("%s done_reached", tag), 64'(finished), 64'd1);
    checkOutput($sformatf("%s words", tag), 64'(cap_data.size()), 64'(v.exp_words));
    if (cap_data.size() > 0) begin
      logic [63:0] w0 = cap_data[0];
      checkOutput($sformatf("%s hdr_word_len", tag), 64'(w0[47:32]), 64'(v.exp_wl));
    end
    if (cap_ctrl.size() >= int'(v.exp_words))
      checkOutput($sformatf("%s last_ctrl", tag), 64'(cap_ctrl[v.exp_words - 1]), 64'(v.exp_last_ctrl));
    checkOutput($sformatf("%s pkt_cnt", tag), 64'(pkt_cnt), 64'(v.num_pkts));
    checkOutput($sformatf("%s byte_cnt", tag), 64'(byte_cnt), v.exp_bytes);
    if (v.check_gap && cap_cyc.size() > int'(v.exp_wl) + 1)
      checkOutput($sformatf("%s idle_gap", tag),
                  64'(cap_cyc[v.exp_wl + 1] - cap_cyc[v.exp_wl] - 1), 64'(v.ipg));
    verifyStream(tag, v.num_pkts, L, v.dst);
    enable = 1'b0;
    repeat (2) tick();
    checkOutput($sformatf("%s done_after_disable", tag), 64'(done), 64'd0);
    checkOutput($sformatf("%s busy_after_disable", tag), 64'(busy), 64'd0);
    checkOutput($sformatf("%s pkt_cnt_held", tag), 64'(pkt_cnt), 64'(v.num_pkts));
  endtask

  initial begin
    bit ok;
    vecs[0] = '{3, 64,   0, 16'h0001, 1'b0, 1'b1, 27,  8,   8'h01, 192};
    vecs[1] = '{1, 61,   0, 16'h0002, 1'b0, 1'b0, 9,   8,   8'h08, 61};
    vecs[2] = '{1, 20,   0, 16'h0004, 1'b0, 1'b0, 9,   8,   8'h10, 60};
    vecs[3] = '{1, 2000, 0, 16'h0008, 1'b0, 1'b0, 191, 190, 8'h40, 1514};
    vecs[4] = '{2, 100,  5, 16'h0010, 1'b0, 1'b1, 28,  13,  8'h10, 200};
    vecs[5] = '{4, 64,   2, 16'h0020, 1'b1, 1'b0, 36,  8,   8'h01, 256};

    reset = 1'b1; enable = 1'b0; num_pkts = 0; pkt_len = 0; ipg_cycles = 0; dst_port = 0;
    repeat (3) tick();
    checkOutput("reset out_wr", 64'(out_wr), 64'd0);
    checkOutput("reset out_data", out_data, 64'd0);
    checkOutput("reset out_ctrl", 64'(out_ctrl), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("reset byte_cnt", 64'(byte_cnt), 64'd0);
    checkOutput("reset time_first", time_first, 64'd0);

    // Enable already high when reset releases must not start a run
    num_pkts = 1; pkt_len = 64; enable = 1'b1;
    tick();
    reset = 1'b0;
    clearCapture();
    repeat (10) tick();
    checkOutput("enable_level_no_start busy", 64'(busy), 64'd0);
    checkOutput("enable_level_no_start words", 64'(cap_data.size()), 64'd0);
    enable = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) runVector(vecs[k], $sformatf("vec%0d", k));

    for (int r = 0; r < 4; r++) begin
      vec_t v;
      int unsigned L;
      v.num_pkts  = $urandom_range(1, 3);
      v.pkt_len   = $urandom_range(0, 2100);
      v.ipg       = $urandom_range(0, 4);
      v.dst       = 16'(1 << $urandom_range(0, 15));
      v.rr        = 1'($urandom_range(0, 1));
      v.check_gap = !v.rr && (v.num_pkts > 1);
      L           = clampLen(v.pkt_len);
      v.exp_wl    = (L + 7) / 8;
      v.exp_words = v.num_pkts * (v.exp_wl + 1);
      v.exp_last_ctrl = 8'h80 >> ((L - 1) % 8);
      v.exp_bytes = longint'(v.num_pkts) * L;
      runVector(v, $sformatf("rand%0d", r));
    end

    // Unlimited run, enable dropped during payload word 3 of the third packet
    startRun(0, 64, 0, 16'h0040, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      tick();
      if (cap_data.size() >= 23) ok = 1'b1;
    end
    checkOutput("drop_enable reached_word3", 64'(ok), 64'd1);
    enable = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      tick();
      if (busy === 1'b0) ok = 1'b1;
    end
    checkOutput("drop_enable went_idle", 64'(ok), 64'd1);
    checkOutput("drop_enable done", 64'(done), 64'd0);
    checkOutput("drop_enable pkt_cnt", 64'(pkt_cnt), 64'd3);
    checkOutput("drop_enable byte_cnt", 64'(byte_cnt), 64'd192);
    verifyStream("drop_enable", 3, 64, 16'h0040);

    // Reset in the middle of a payload aborts at once
    startRun(0, 64, 0, 16'h0080, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      tick();
      if (cap_data.size() >= 12) ok = 1'b1;
    end
    checkOutput("mid_reset reached_payload", 64'(ok), 64'd1);
    checkOutput("mid_reset pkt_cnt_before", 64'(pkt_cnt), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("mid_reset out_wr", 64'(out_wr), 64'd0);
    checkOutput("mid_reset pkt_cnt", 64'(pkt_cnt), 64'd0);
    checkOutput("mid_reset byte_cnt", 64'(byte_cnt), 64'd0);
    checkOutput("mid_reset busy", 64'(busy), 64'd0);
    checkOutput("mid_reset out_data", out_data, 64'd0);
    tick();
    reset = 1'b0;
    clearCapture();
    repeat (20) tick();
    checkOutput("mid_reset no_restart", 64'(cap_data.size()), 64'd0);
    enable = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
